// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, fed by a small circular FIFO.
// Back-to-back frames leave the line with no idle gap between them.
module uart_tx #(
  parameter int CLKS_PER_BIT = 120,
  parameter int FIFO_ADDR_W  = 2
) (
  input  logic                 I_clk,
  input  logic                 I_reset_n,
  input  logic [7:0]           I_data,
  input  logic                 I_data_valid,
  output logic                 O_ready,
  output logic                 O_data_bit,
  output logic                 O_busy,
  output logic [FIFO_ADDR_W:0] O_fifo_count
);

  localparam int DEPTH = 1 << FIFO_ADDR_W;
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_ADDR_W:0] FULL =
    {1'b1, {FIFO_ADDR_W{1'b0}}};
  localparam logic [FIFO_ADDR_W:0] ONE =
    {{FIFO_ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                 r_state;
  logic [7:0]             r_mem [DEPTH];
  logic [FIFO_ADDR_W-1:0] r_wr_ptr;
  logic [FIFO_ADDR_W-1:0] r_rd_ptr;
  logic [FIFO_ADDR_W:0]   r_count;
  logic [7:0]             r_shift;
  logic [15:0]            r_clk_cnt;
  logic [2:0]             r_bit_idx;

  logic w_have;
  logic w_bit_end;
  logic w_wr;
  logic w_pop;

  assign w_have       = (r_count != '0);
  assign w_bit_end    = (r_clk_cnt == LAST);
  assign O_ready      = (r_count != FULL);
  assign w_wr         = I_data_valid && O_ready;
  assign O_fifo_count = r_count;

  // Pops look at the registered count only, so a fresh write waits a cycle.
  assign w_pop = w_have &&
    ((r_state == S_IDLE) ||
     ((r_state == S_STOP) && w_bit_end));

  always_ff @(posedge I_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= I_data;
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr && !w_pop)
        r_count <= r_count + ONE;
      else if (w_pop && !w_wr)
        r_count <= r_count - ONE;
    end
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      O_data_bit <= 1'b1;
      O_busy     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          O_data_bit <= 1'b1;
          O_busy     <= 1'b0;
          r_clk_cnt  <= '0;
          if (w_have) begin
            r_shift    <= r_mem[r_rd_ptr];
            O_data_bit <= 1'b0;
            O_busy     <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            O_data_bit <= r_shift[0];
            r_state    <= S_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              O_data_bit <= 1'b1;
              r_state    <= S_STOP;
            end else begin
              r_shift    <= r_shift >> 1;
              O_data_bit <= r_shift[1];
              r_bit_idx  <= r_bit_idx + 3'd1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (w_have) begin
              r_shift    <= r_mem[r_rd_ptr];
              O_data_bit <= 1'b0;
              r_state    <= S_START;
            end else begin
              O_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: timeline model of frames plus a line decoder.
// Randomised writes are scored against accepted bytes and line shape.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int FRAME = 10 * CPB;

  logic          clk;
  logic          rst_n;
  logic [7:0]    i_data;
  logic          i_valid;
  logic          o_ready;
  logic          o_bit;
  logic          o_busy;
  logic [AW:0]   o_cnt;

  int checks;
  int errors;

  logic [7:0] m_q[$];
  logic [7:0] m_byte;
  int         m_e;
  int         m_start;
  int         m_end;
  logic [7:0] acc_log[$];
  logic       line_log[$];
  int         busy_cyc;

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_ADDR_W (AW)
  ) dut (
    .I_clk       (clk),
    .I_reset_n   (rst_n),
    .I_data      (i_data),
    .I_data_valid(i_valid),
    .O_ready     (o_ready),
    .O_data_bit  (o_bit),
    .O_busy      (o_busy),
    .O_fifo_count(o_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic m_reset();
    m_q.delete();
    m_byte  = 8'h00;
    m_start = m_e;
    m_end   = m_e;
  endtask

  task automatic clear_logs();
    acc_log.delete();
    line_log.delete();
    busy_cyc = 0;
  endtask

  // One clock: drive, advance the frame timeline, compare all outputs.
  task automatic step(input logic v, input logic [7:0] d);
    int         pre;
    logic       acc;
    logic       e_busy;
    logic       e_line;
    logic [9:0] fr;
    int         k;
    i_valid = v;
    i_data  = d;
    @(posedge clk);
    m_e++;
    pre = m_q.size();
    acc = v && (pre < DEPTH);
    if (pre > 0 && m_e >= m_end) begin
      m_byte  = m_q.pop_front();
      m_start = m_e;
      m_end   = m_e + FRAME;
    end
    if (acc) begin
      m_q.push_back(d);
      acc_log.push_back(d);
    end
    #1;
    i_valid = 1'b0;
    i_data  = 8'($urandom);
    e_busy  = (m_e < m_end);
    fr      = {1'b1, m_byte, 1'b0};
    k       = (m_e - m_start) / CPB;
    e_line  = e_busy ? fr[k] : 1'b1;
    line_log.push_back(o_bit);
    if (o_busy) busy_cyc++;
    checks += 4;
    if (o_bit !== e_line) begin
      errors++;
      $display("FAIL line cyc=%0d got %b exp %b",
               m_e, o_bit, e_line);
    end
    if (o_busy !== e_busy) begin
      errors++;
      $display("FAIL busy cyc=%0d got %b exp %b",
               m_e, o_busy, e_busy);
    end
    if (o_cnt !== (AW+1)'(m_q.size())) begin
      errors++;
      $display("FAIL count cyc=%0d got %0d exp %0d",
               m_e, o_cnt, m_q.size());
    end
    if (o_ready !== (m_q.size() < DEPTH)) begin
      errors++;
      $display("FAIL ready cyc=%0d got %b exp %b",
               m_e, o_ready, (m_q.size() < DEPTH));
    end
  endtask

  // Independent receiver: find start bits, sample mid-bit.
  task automatic check_decode(input string name);
    logic [7:0] got[$];
    logic [7:0] b;
    int         i;
    int         n;
    int         ok;
    n = line_log.size();
    i = 0;
    ok = 1;
    while (i < n) begin
      if (line_log[i] == 1'b0) begin
        if (i + FRAME > n) begin
          ok = 0;
          break;
        end
        for (int j = 0; j < 8; j++)
          b[j] = line_log[i + CPB*(1+j) + CPB/2];
        if (line_log[i + 9*CPB + CPB/2] != 1'b1) ok = 0;
        got.push_back(b);
        i += FRAME;
      end else begin
        i++;
      end
    end
    checks++;
    if (!ok || got.size() != acc_log.size()) begin
      errors++;
      $display("FAIL %s frames got %0d exp %0d ok=%0d",
               name, got.size(), acc_log.size(), ok);
    end else begin
      for (int j = 0; j < got.size(); j++) begin
        checks++;
        if (got[j] !== acc_log[j]) begin
          errors++;
          $display("FAIL %s byte%0d got %h exp %h",
                   name, j, got[j], acc_log[j]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (o_bit !== 1'b1) begin
      errors++;
      $display("FAIL rst_line got %b exp 1", o_bit);
    end
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got %b exp 0", o_busy);
    end
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready got %b exp 1", o_ready);
    end
    if (o_cnt !== '0) begin
      errors++;
      $display("FAIL rst_count got %0d exp 0", o_cnt);
    end
    i_valid = 1'b1;
    i_data  = 8'h5A;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    checks++;
    if (o_cnt !== '0) begin
      errors++;
      $display("FAIL rst_write got %0d exp 0", o_cnt);
    end
    rst_n = 1'b1;
    m_e = 0;
    m_reset();
  endtask

  task automatic test_idle();
    clear_logs();
    repeat (1000) step(1'b0, 8'($urandom));
  endtask

  task automatic test_single();
    clear_logs();
    step(1'b1, 8'hA5);
    repeat (50) step(1'b0, 8'($urandom));
    checks++;
    if (busy_cyc != FRAME) begin
      errors++;
      $display("FAIL single_busy got %0d exp %0d",
               busy_cyc, FRAME);
    end
    check_decode("single");
  endtask

  task automatic test_back_to_back();
    clear_logs();
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    step(1'b1, 8'h55);
    repeat (3*FRAME + 10) step(1'b0, 8'($urandom));
    checks++;
    if (busy_cyc != 3*FRAME) begin
      errors++;
      $display("FAIL b2b_busy got %0d exp %0d",
               busy_cyc, 3*FRAME);
    end
    check_decode("b2b");
  endtask

  task automatic test_overflow();
    clear_logs();
    for (int i = 0; i < 6; i++)
      step(1'b1, 8'(8'h10 + i));
    checks++;
    if (acc_log.size() != 5) begin
      errors++;
      $display("FAIL ovf_accept got %0d exp 5",
               acc_log.size());
    end
    repeat (5*FRAME + 10) step(1'b0, 8'($urandom));
    check_decode("overflow");
  endtask

  task automatic test_simul();
    int n;
    clear_logs();
    step(1'b1, 8'h3C);
    step(1'b1, 8'hC3);
    n = 0;
    while (m_e + 1 != m_end && n < 2*FRAME) begin
      step(1'b0, 8'($urandom));
      n++;
    end
    checks++;
    if (n >= 2*FRAME) begin
      errors++;
      $display("FAIL simul_wait got %0d exp <%0d",
               n, 2*FRAME);
    end
    step(1'b1, 8'h96);
    checks++;
    if (o_cnt !== (AW+1)'(1)) begin
      errors++;
      $display("FAIL simul_count got %0d exp 1", o_cnt);
    end
    repeat (2*FRAME + 10) step(1'b0, 8'($urandom));
    check_decode("simul");
  endtask

  task automatic test_reset_mid();
    int n;
    clear_logs();
    step(1'b1, 8'hA1);
    step(1'b1, 8'hB2);
    step(1'b1, 8'hC3);
    n = 0;
    while (m_e - m_start != 4*CPB + 1 && n < 2*FRAME) begin
      step(1'b0, 8'($urandom));
      n++;
    end
    checks++;
    if (o_cnt !== (AW+1)'(2)) begin
      errors++;
      $display("FAIL mid_pre got %0d exp 2", o_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (o_bit !== 1'b1) begin
      errors++;
      $display("FAIL mid_line got %b exp 1", o_bit);
    end
    if (o_cnt !== '0) begin
      errors++;
      $display("FAIL mid_count got %0d exp 0", o_cnt);
    end
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_busy got %b exp 0", o_busy);
    end
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_reset();
    clear_logs();
    repeat (3*FRAME) step(1'b0, 8'($urandom));
    check_decode("mid_after");
  endtask

  task automatic test_random();
    int rate;
    clear_logs();
    for (int p = 0; p < 6; p++) begin
      rate = $urandom_range(1, 12);
      repeat (150)
        step($urandom_range(1, rate) == 1, 8'($urandom));
    end
    repeat (DEPTH*FRAME + FRAME + 10)
      step(1'b0, 8'($urandom));
    check_decode("random");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_overflow();
    test_simul();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
